// File: rtl/mem_burst_master_if.sv
// Bus bundle for mem_burst_master: command, write-beat and read-beat
// channels plus the simple single-port memory side.
//
// Handshakes: each channel transfers exactly on a cycle where both valid and
// ready are high at posedge clk. The sender keeps its payload stable while
// valid is high and ready is low. The receiver may raise ready without valid.
interface mem_burst_master_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [9:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       rd_data;
  logic             done;
  logic             mem_rw_select;
  logic [9:0]       mem_address;
  logic [7:0]       mem_data_in;
  logic [7:0]       mem_data_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, done,
    output mem_rw_select, mem_address, mem_data_in
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done,
    input  mem_rw_select, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst master: takes a burst command, then streams write beats into a
// memory with 1-cycle registered read latency, or reads beats out of it one
// at a time (issue, capture, hold until consumed). done pulses for one cycle
// after the final beat of every burst.
module mem_burst_master #(
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_burst_master_if.master     bus,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_RD_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       addr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;
  logic             cmd_fire;
  logic             wr_beat;
  logic             rd_beat;
  logic             last_beat;

  assign last_beat = (cnt_q == '0);

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode. Write beats are gated by rst_n so that
  // the memory sees no write strobe in a cycle where reset is asserted.
  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.done      = 1'b0;
    cmd_fire      = 1'b0;
    wr_beat       = 1'b0;
    rd_beat       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cmd_fire = 1'b1;
          state_d  = bus.cmd_write ? S_WRITE : S_RD_ISSUE;
        end
      end
      S_WRITE: begin
        bus.wr_ready = rst_n;
        if (bus.wr_valid && rst_n) begin
          wr_beat = 1'b1;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_CAPT;
      S_RD_CAPT:  state_d = S_RD_HOLD;
      S_RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_beat = 1'b1;
          state_d = last_beat ? S_DONE : S_RD_ISSUE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst datapath: address/beat counter, read capture and read-valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q <= bus.cmd_addr;
        cnt_q  <= bus.cmd_len;
      end
      if (wr_beat || rd_beat) begin
        addr_q <= addr_q + 10'd1;
        if (!last_beat) cnt_q <= cnt_q - LEN_W'(1);
      end
      if (state_q == S_RD_CAPT) begin
        rd_data_q  <= bus.mem_data_out;
        rd_valid_q <= 1'b1;
      end
      if (rd_beat) rd_valid_q <= 1'b0;
    end
  end

  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.mem_rw_select = wr_beat;
  assign bus.mem_address   = addr_q;
  assign bus.mem_data_in   = bus.wr_data;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 1024x8 memory that
// has one cycle of registered read latency.
module tb_mem_burst_master;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         errors;
  int         checks;

  logic [7:0]  mem [0:1023];
  logic [17:0] wr_log [$];
  logic [17:0] exp_q  [$];

  mem_burst_master_if #(.LEN_W(8)) bus ();

  mem_burst_master #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and write monitor
  always @(posedge clk) begin
    if (bus.mem_rw_select) begin
      mem[bus.mem_address] <= bus.mem_data_in;
      wr_log.push_back({bus.mem_address, bus.mem_data_in});
    end
    bus.mem_data_out <= mem[bus.mem_address];
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic wr, input logic [9:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    #1;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready low for %0d cycles, required high", n);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b want 0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h want 00", bus.rd_data); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if (bus.mem_rw_select !== 1'b0) begin errors++; $display("FAIL rst_rw_select: got %b want 0", bus.mem_rw_select); end
    checks++; if (bus.mem_address !== 10'h000) begin errors++; $display("FAIL rst_address: got %h want 000", bus.mem_address); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Write 0x010..0x013 with A0..A3, cmd_valid held high to show it is ignored.
  task automatic test_write_burst();
    wr_log.delete();
    send_cmd(1'b1, 10'h010, 8'd3);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hA0 + 8'(i);
      #1;
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready beat%0d: got %b want 1", i, bus.wr_ready); end
      checks++; if (bus.mem_rw_select !== 1'b1) begin errors++; $display("FAIL wr_select beat%0d: got %b want 1", i, bus.mem_rw_select); end
      checks++; if (bus.mem_address !== 10'h010 + 10'(i)) begin errors++; $display("FAIL wr_address beat%0d: got %h want %h", i, bus.mem_address, 10'h010 + 10'(i)); end
      checks++; if (bus.mem_data_in !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wr_data beat%0d: got %h want %h", i, bus.mem_data_in, 8'hA0 + 8'(i)); end
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ignored beat%0d: cmd_ready got %b want 0", i, bus.cmd_ready); end
      @(negedge clk);
    end
    bus.wr_valid  = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wr_done: got %b want 1", bus.done); end
    checks++; if (bus.mem_rw_select !== 1'b0) begin errors++; $display("FAIL wr_done_select: got %b want 0", bus.mem_rw_select); end
    @(negedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready_after: got %b want 1", bus.cmd_ready); end
    exp_q = '{ {10'h010, 8'hA0}, {10'h011, 8'hA1}, {10'h012, 8'hA2}, {10'h013, 8'hA3} };
    checks++; if (wr_log.size() !== 4) begin errors++; $display("FAIL wr_count: got %0d want 4", wr_log.size()); end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL wr_log%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
    @(negedge clk);
  endtask

  // Read back 0x010..0x013 with rd_ready tied high.
  task automatic test_read_burst();
    int nbeats;
    int ndone;
    int done_k;
    nbeats = 0;
    ndone  = 0;
    done_k = -1;
    wr_log.delete();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 8'd3);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.rd_valid) begin
        checks++; if (bus.rd_data !== 8'hA0 + 8'(nbeats)) begin errors++; $display("FAIL rd_data beat%0d: got %h want %h", nbeats, bus.rd_data, 8'hA0 + 8'(nbeats)); end
        checks++; if (k !== 2 + 3 * nbeats) begin errors++; $display("FAIL rd_timing beat%0d: cycle %0d want %0d", nbeats, k, 2 + 3 * nbeats); end
        nbeats++;
      end
      if (bus.done) begin
        ndone++;
        done_k = k;
      end
      @(negedge clk);
    end
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL rd_beats: got %0d want 4", nbeats); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL rd_done_count: got %0d want 1", ndone); end
    checks++; if (done_k !== 12) begin errors++; $display("FAIL rd_done_cycle: got %0d want 12", done_k); end
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL rd_no_writes: got %0d writes want 0", wr_log.size()); end
  endtask

  // Single-beat read of 0x012 held off by rd_ready for 5 cycles.
  task automatic test_read_hold();
    wr_log.delete();
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 10'h012, 8'd0);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d: got %b want 1", j, bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'hA2) begin errors++; $display("FAIL hold_data c%0d: got %h want a2", j, bus.rd_data); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_done c%0d: got %b want 0", j, bus.done); end
      @(negedge clk);
    end
    bus.rd_ready = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL hold_release_valid: got %b want 1", bus.rd_valid); end
    @(negedge clk);
    bus.rd_ready = 1'b0;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_drop: got %b want 0", bus.rd_valid); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b want 1", bus.done); end
    @(negedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL hold_no_writes: got %0d want 0", wr_log.size()); end
  endtask

  // Write burst crossing the top of the address space.
  task automatic test_wrap();
    logic [7:0] d [3];
    d = '{8'h11, 8'h22, 8'h33};
    wr_log.delete();
    send_cmd(1'b1, 10'h3FE, 8'd2);
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = d[i];
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", bus.done); end
    checks++; if (bus.mem_address !== 10'h001) begin errors++; $display("FAIL wrap_addr_after: got %h want 001", bus.mem_address); end
    exp_q = '{ {10'h3FE, 8'h11}, {10'h3FF, 8'h22}, {10'h000, 8'h33} };
    checks++; if (wr_log.size() !== 3) begin errors++; $display("FAIL wrap_count: got %0d want 3", wr_log.size()); end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_log%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
    @(negedge clk);
  endtask

  // len=7 write with wr_valid low every other cycle.
  task automatic test_gaps();
    int beats;
    int c;
    beats = 0;
    c     = 0;
    wr_log.delete();
    send_cmd(1'b1, 10'h100, 8'd7);
    while (beats < 8 && c < 40) begin
      if (c % 2 == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h50 + 8'(beats);
        #1;
        checks++; if (bus.mem_rw_select !== 1'b1) begin errors++; $display("FAIL gap_beat_select b%0d: got %b want 1", beats, bus.mem_rw_select); end
        beats++;
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'hEE;
        #1;
        checks++; if (bus.mem_rw_select !== 1'b0) begin errors++; $display("FAIL gap_select c%0d: got %b want 0", c, bus.mem_rw_select); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL gap_wr_ready c%0d: got %b want 1", c, bus.wr_ready); end
      end
      @(negedge clk);
      c++;
    end
    bus.wr_valid = 1'b0;
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b want 1", bus.done); end
    checks++; if (wr_log.size() !== 8) begin errors++; $display("FAIL gap_count: got %0d want 8", wr_log.size()); end
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== {10'h100 + 10'(i), 8'h50 + 8'(i)}) begin errors++; $display("FAIL gap_log%0d: got %h want %h", i, wr_log[i], {10'h100 + 10'(i), 8'h50 + 8'(i)}); end
    end
    @(negedge clk);
  endtask

  // Reset after the 2nd beat of a len=5 write, then a fresh read.
  task automatic test_reset_mid_burst();
    wr_log.delete();
    send_cmd(1'b1, 10'h200, 8'd5);
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h60 + 8'(i);
      @(negedge clk);
    end
    bus.wr_data = 8'h62;
    rst_n       = 1'b0;
    #1;
    checks++; if (bus.mem_rw_select !== 1'b0) begin errors++; $display("FAIL mid_rst_select: got %b want 0", bus.mem_rw_select); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_ready: got %b want 0", bus.wr_ready); end
    @(negedge clk);
    #1;
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL mid_rst_state: got %0d want 0", dbg_state); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL mid_rst_rd_data: got %h want 00", bus.rd_data); end
    checks++; if (bus.mem_address !== 10'h000) begin errors++; $display("FAIL mid_rst_address: got %h want 000", bus.mem_address); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", bus.done); end
    rst_n        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 8'd0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL post_rst_rd_valid: got %b want 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'hA0) begin errors++; $display("FAIL post_rst_rd_data: got %h want a0", bus.rd_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL post_rst_done: got %b want 1", bus.done); end
    exp_q = '{ {10'h200, 8'h60}, {10'h201, 8'h61} };
    checks++; if (wr_log.size() !== 2) begin errors++; $display("FAIL mid_rst_count: got %0d want 2", wr_log.size()); end
    for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL mid_rst_log%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
    @(negedge clk);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;

    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_hold();
    test_wrap();
    test_gaps();
    test_reset_mid_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
